// File: rtl/us_tick_gen.sv
// Microsecond tick generator with optional 1PPS discipline.
// Free-running clk divider feeds a microsecond-of-second counter; PPS edges realign and drive a lock FSM.
module us_tick_gen #(
    parameter int unsigned DIV        = 100,
    parameter int unsigned HIGH_LEN   = 50,
    parameter int unsigned TOL_US     = 2,
    parameter int unsigned LOCK_N     = 3,
    // Microseconds per second; only lowered to shorten simulated seconds.
    parameter int unsigned US_PER_SEC = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pps,
    input  logic        pps_en,
    output logic        t1us,
    output logic [19:0] us_in_sec,
    output logic        sec_pulse,
    output logic        pps_lock,
    output logic        pps_err
);

    typedef enum logic [1:0] {FREE, ACQUIRE, LOCKED} state_t;

    localparam logic [15:0] CNT_MAX  = 16'(DIV - 1);
    localparam logic [15:0] HIGH_CNT = 16'(HIGH_LEN);
    localparam logic [19:0] US_MAX   = 20'(US_PER_SEC - 1);
    localparam logic [19:0] TOL_LO   = 20'(TOL_US);
    localparam logic [19:0] TOL_HI   = 20'(US_PER_SEC - TOL_US);
    localparam logic [3:0]  LOCK_THR = 4'(LOCK_N);

    state_t      state, state_next;
    logic        pps_s1, pps_s2, pps_s3;
    logic        pps_edge;
    logic [15:0] cnt;
    logic [3:0]  good_cnt, good_inc;
    logic        armed, seen;
    logic        us_step, fr_wrap;
    logic        tracking, realign, judged, in_window;
    logic        good_edge, bad_edge, missing;

    assign pps_edge = pps_s2 & ~pps_s3;
    assign us_step  = (cnt == CNT_MAX);
    assign fr_wrap  = us_step && (us_in_sec == US_MAX);

    always_ff @(posedge clk) begin
        if (reset) state <= FREE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FREE:    if (pps_en) state_next = ACQUIRE;
            ACQUIRE: if (!(bad_edge || missing) && good_edge && (good_inc >= LOCK_THR))
                         state_next = LOCKED;
            LOCKED:  if (bad_edge || missing) state_next = ACQUIRE;
            default: state_next = FREE;
        endcase
        if (!pps_en) state_next = FREE;
    end

    always_comb begin
        tracking  = (state != FREE);
        realign   = tracking & pps_edge;
        // the first edge after entering ACQUIRE only establishes alignment
        judged    = realign & seen;
        in_window = (us_in_sec >= TOL_HI) || (us_in_sec < TOL_LO);
        good_edge = judged & in_window;
        bad_edge  = judged & ~in_window;
        missing   = tracking & armed & ~pps_edge & (us_in_sec == TOL_LO) & (cnt == '0);
        good_inc  = (good_cnt == '1) ? good_cnt : good_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pps_s1    <= 1'b0;
            pps_s2    <= 1'b0;
            pps_s3    <= 1'b0;
            cnt       <= '0;
            us_in_sec <= '0;
            t1us      <= 1'b0;
            sec_pulse <= 1'b0;
            pps_err   <= 1'b0;
            pps_lock  <= 1'b0;
            good_cnt  <= '0;
            armed     <= 1'b0;
            seen      <= 1'b0;
        end else begin
            pps_s1    <= pps;
            pps_s2    <= pps_s1;
            pps_s3    <= pps_s2;
            t1us      <= (cnt < HIGH_CNT);
            // a realign right after a free-run wrap must not emit a second pulse
            sec_pulse <= fr_wrap | (realign & ~sec_pulse);
            pps_err   <= bad_edge | missing;
            pps_lock  <= (state_next == LOCKED);

            if (realign) begin
                cnt       <= '0;
                us_in_sec <= '0;
            end else if (us_step) begin
                cnt       <= '0;
                us_in_sec <= fr_wrap ? '0 : us_in_sec + 20'd1;
            end else begin
                cnt       <= cnt + 16'd1;
            end

            if (!tracking || pps_edge || missing) armed <= 1'b0;
            else if (fr_wrap)                     armed <= 1'b1;

            if (!tracking)    seen <= 1'b0;
            else if (realign) seen <= 1'b1;

            if (!tracking || bad_edge || missing) good_cnt <= '0;
            else if (good_edge)                   good_cnt <= good_inc;
        end
    end

endmodule
